// File: rtl/dmem_access_ctrl_if.sv
// Bundle of MEM-stage control, data-memory bus and status signals for
// dmem_access_ctrl. The master side is the controller; the slave side is
// the surrounding pipeline/memory environment.
interface dmem_access_ctrl_if #(
  parameter int DATA_W = 32
);
  // Pipeline side
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              err_clr;
  logic [DATA_W-1:0] rdata_out;
  logic              stall;
  logic              misalign_err;
  logic              timeout_err;
  // Memory side
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ready;
  logic [DATA_W-1:0] dmem_rdata;

  modport master (
    input  mem_read, mem_write, addr, wdata, err_clr, dmem_ready, dmem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_out, stall,
           misalign_err, timeout_err
  );

  modport slave (
    output mem_read, mem_write, addr, wdata, err_clr, dmem_ready, dmem_rdata,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, rdata_out, stall,
           misalign_err, timeout_err
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access controller. Turns the EX/MEM load/store
// bits into a single registered memory request, stalls the front of the
// pipeline while the request is outstanding, aborts after TIMEOUT cycles
// without a ready, and flags misaligned word accesses.
module dmem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  dmem_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Last wait-cycle count before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] cnt;
  logic       op;
  logic       aligned;
  logic       launch;
  logic       complete;
  logic       abort;
  logic       mis_set;
  logic       stall_int;

  assign op      = bus.mem_read | bus.mem_write;
  assign aligned = (bus.addr[1:0] == 2'b00);

  // Stall is masked by reset so a held op cannot freeze the pipeline in reset.
  assign bus.stall = stall_int & ~rst;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode plus the per-cycle event strobes and the stall term.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    mis_set   = 1'b0;
    stall_int = 1'b0;
    unique case (state)
      IDLE: begin
        if (op) begin
          if (aligned) begin
            launch    = 1'b1;
            stall_int = 1'b1;
            state_nxt = ACCESS;
          end else begin
            mis_set = 1'b1;
          end
        end
      end
      ACCESS: begin
        stall_int = 1'b1;
        if (bus.dmem_ready) begin
          complete  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CNT_LAST) begin
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request registers: captured on launch, held stable until the access ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
    end else if (launch) begin
      bus.dmem_req   <= 1'b1;
      bus.dmem_we    <= bus.mem_write;
      bus.dmem_addr  <= bus.addr;
      bus.dmem_wdata <= bus.wdata;
    end else if (complete || abort) begin
      bus.dmem_req   <= 1'b0;
    end
  end

  // Wait-cycle counter: restarts on each launch, counts non-ready ACCESS cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     cnt <= '0;
    else if (launch)                             cnt <= '0;
    else if (state == ACCESS && !bus.dmem_ready) cnt <= cnt + 8'd1;
  end

  // Load result: memory data on a completed load, zero on any failed access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                           bus.rdata_out <= '0;
    else if (mis_set || abort)         bus.rdata_out <= '0;
    else if (complete && !bus.dmem_we) bus.rdata_out <= bus.dmem_rdata;
  end

  // Sticky error flags; a new error in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.misalign_err <= 1'b0;
      bus.timeout_err  <= 1'b0;
    end else begin
      bus.misalign_err <= mis_set | (bus.misalign_err & ~bus.err_clr);
      bus.timeout_err  <= abort   | (bus.timeout_err  & ~bus.err_clr);
    end
  end

endmodule
